rx_word_gate: RTL and testbench
===============================

# rx_word_gate

Parametrised output stage for the RMII receive path. It takes the post-firewall dibit stream (payload followed by the 32-bit FCS), removes the FCS, and packs the payload MSB-first into WIDTH-bit words. Words are held in a MAX_WORDS-deep buffer and released only after the checksum block reports a good FCS. Bad, oversized or timed-out frames are discarded whole. It replaces the fixed 44-bit aggregator, which ignored the FCS verdict.

## Interface
- WIDTH, 44: output word width in bits; must be even and at least 4.
- MAX_WORDS, 4: buffer depth in words; at least 1.
- FCS_DIBITS, 16: trailing dibits stripped from every frame (32-bit FCS).
- TIMEOUT, 256: cycles to wait in WAIT_CK for a verdict before dropping the frame.
- clk  in  1  RMII reference clock (50 MHz); the only clock.
- rst  in  1  asynchronous, active-high reset.
- axiiv  in  1  input dibit valid; high for the whole frame, and a falling edge marks frame end.
- axiid  in  2  input dibit, MSB-first order as produced by bitorder.
- done  in  1  one-cycle pulse from cksum: FCS verdict available.
- kill  in  1  qualified by done: 1 means FCS bad.
- axior  in  1  downstream ready.
- axiov  out  1  output word valid.
- axiod  out  WIDTH  output word.
- axiol  out  1  high with the last word of a frame.
- drop  out  1  one-cycle pulse when a frame is discarded.
- miss  out  1  one-cycle pulse on the first dibit of a frame ignored while busy.

## Operation
- States:
  - IDLE: waiting for a frame.
  - COLLECT: receiving dibits.
  - WAIT_CK: frame ended, waiting for the FCS verdict.
  - DRAIN: presenting buffered words downstream.
- IDLE → COLLECT on axiiv=1. That first dibit is captured. Capture clears the dibit count, word pointer, overflow flag and verdict latch.
- FCS removal: each dibit enters a FCS_DIBITS-deep shift delay line. A dibit reaches the packer only when it is pushed out by a newer dibit. The last FCS_DIBITS dibits of a frame never reach the packer.
- Packer: word <= {word[WIDTH-3:0], dibit}. After WIDTH/2 packed dibits, the word is written to buffer[wptr] and wptr increments.
  - A write attempted when wptr = MAX_WORDS sets the overflow flag and is not stored.
  - A partial trailing word (fewer than WIDTH/2 dibits) is discarded.
- Verdict latch: done is sampled in COLLECT and WAIT_CK and stores {seen=1, bad=kill}. Verdicts arriving in IDLE or DRAIN are ignored. Because cksum observes the frame earlier, the verdict may arrive before frame end.
- COLLECT → WAIT_CK on axiiv falling (axiiv=0 after 1).
- WAIT_CK resolves when the verdict is seen, checking this cycle's done as well as the latch:
  - bad, overflow, or wptr=0: pulse drop, go to IDLE.
  - otherwise: go to DRAIN with rptr=0.
  - If no verdict arrives within TIMEOUT cycles of entering WAIT_CK: pulse drop, go to IDLE.
- DRAIN:
  - axiov=1, axiod=buffer[rptr], axiol=(rptr==wptr-1).
  - When axiov and axior are both high, rptr increments.
  - Acceptance of the axiol word goes to IDLE.
- Busy: axiiv rising in WAIT_CK or DRAIN pulses miss. That frame is ignored until axiiv falls. Capture resumes on the next rising edge seen in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - axiov=0, axiod=0, axiol=0, drop=0, miss=0.
  - State IDLE; pointers, counters and latches cleared.
  - The buffer contents are don't-care.
- Reset takes effect mid-frame or mid-drain; nothing is output afterwards. A frame whose axiiv is high when rst deasserts is treated as starting on the first cycle the block sees axiiv=1 in IDLE.
- Verdict latency: a verdict that arrives before frame end is honoured. The earliest cases are:
  - done pulse coincident with the cycle WAIT_CK is entered: DRAIN is entered the next cycle and axiov rises that cycle.
  - done in cycle t while already in WAIT_CK: DRAIN at t+1, axiov high at t+1.
- Drop: one-cycle pulse, in the cycle after the resolving condition, coincident with the return to IDLE.
- Output handshake:
  - axiod and axiol are stable while axiov=1 and axior=0.
  - At most one word is accepted per cycle.
  - axiov is low the cycle after the axiol word is accepted.
- Throughput: the next frame can be captured from the first IDLE cycle. Back-to-back frames need one idle cycle between axiiv low and high.
- All outputs are registered.

## Test plan
- Good frame, WIDTH=44: 88 payload bits (0xABC…) plus 16 FCS dibits, done/kill=0 two cycles after axiiv falls, axior=1.
  - Required: two words on consecutive cycles, equal to the payload MSB-first; axiol on the second; no drop.
- Same frame with kill=1.
  - Required: axiov never asserts; drop pulses once.
- Verdict early: done (good) arrives 10 cycles before axiiv falls.
  - Required: DRAIN entered the cycle after frame end; words correct.
- Overflow, MAX_WORDS=2: three full payload words, good FCS.
  - Required: drop pulses once; no axiov.
  - Then a following 1-word good frame outputs that word with axiol=1.
- Backpressure: axior low for 5 cycles during word 0.
  - Required: axiod and axiol stay constant; word 1 appears only after acceptance.
- Assert rst while in DRAIN after word 0 is accepted.
  - Required: all outputs go to 0 immediately; no further words.
- Also cover:
  - no verdict for TIMEOUT cycles → drop.
  - a frame arriving during DRAIN → miss pulse, frame ignored.

Source files
------------

// File: rtl/rx_word_gate.sv
// rx_word_gate
//   Output stage of the RMII receive path. Strips the trailing FCS from the
//   incoming dibit stream, packs the payload MSB-first into WIDTH-bit words,
//   holds them in a MAX_WORDS-deep buffer and releases them downstream only
//   once the checksum block reports a good FCS. Bad, oversized and timed-out
//   frames are discarded whole.
//
// Ports
//   clk    in   RMII reference clock, the only clock
//   rst    in   asynchronous active-high reset
//   axiiv  in   input dibit valid, high for the whole frame
//   axiid  in   input dibit, MSB-first
//   done   in   one-cycle pulse, FCS verdict available
//   kill   in   qualified by done, 1 = FCS bad
//   axior  in   downstream ready
//   axiov  out  output word valid
//   axiod  out  output word
//   axiol  out  last word of the frame
//   drop   out  one-cycle pulse when a frame is discarded
//   miss   out  one-cycle pulse when a frame starts while busy
module rx_word_gate #(
    parameter int WIDTH      = 44,
    parameter int MAX_WORDS  = 4,
    parameter int FCS_DIBITS = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [1:0]       axiid,
    input  logic             done,
    input  logic             kill,
    input  logic             axior,
    output logic             axiov,
    output logic [WIDTH-1:0] axiod,
    output logic             axiol,
    output logic             drop,
    output logic             miss
);

    localparam int PTR_W  = $clog2(MAX_WORDS + 1);
    localparam int IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int FILL_W = $clog2(FCS_DIBITS + 1);
    localparam int PACK_W = $clog2(WIDTH / 2);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(MAX_WORDS);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FCS_DIBITS);
    localparam logic [PACK_W-1:0] PACK_ONE  = PACK_W'(1);
    localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(WIDTH / 2 - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_CK,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                prevValid_q;
    logic                ignore_q, ignore_d;
    logic [1:0]          dly_q [FCS_DIBITS];
    logic [1:0]          dly_d [FCS_DIBITS];
    logic [FILL_W-1:0]   fillCnt_q, fillCnt_d;
    logic [WIDTH-1:0]    word_q, word_d;
    logic [PACK_W-1:0]   packCnt_q, packCnt_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic                overflow_q, overflow_d;
    logic                seen_q, seen_d;
    logic                bad_q, bad_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                axiov_q, axiov_d;
    logic [WIDTH-1:0]    axiod_q, axiod_d;
    logic                axiol_q, axiol_d;
    logic                drop_q, drop_d;
    logic                miss_q, miss_d;

    logic [WIDTH-1:0]    buffer_q [MAX_WORDS];
    logic                bufWe;
    logic [WIDTH-1:0]    bufWData;

    logic                busyRise;
    logic                verdictSeen;
    logic                verdictBad;
    logic [PTR_W-1:0]    rptrInc;
    logic [PTR_W-1:0]    lastPtr;

    assign rptrInc = rptr_q + PTR_ONE;
    assign lastPtr = wptr_q - PTR_ONE;

    // Next-state and registered-output logic. Outputs are computed from the
    // next state so that axiov rises in the very cycle DRAIN is entered.
    // The delay line only feeds the packer once it is full, which is what
    // keeps the last FCS_DIBITS dibits of every frame away from the words.
    always_comb begin
        state_d    = state_q;
        ignore_d   = ignore_q;
        dly_d      = dly_q;
        fillCnt_d  = fillCnt_q;
        word_d     = word_q;
        packCnt_d  = packCnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        seen_d     = seen_q;
        bad_d      = bad_q;
        timer_d    = timer_q;
        axiov_d    = axiov_q;
        axiod_d    = axiod_q;
        axiol_d    = axiol_q;
        drop_d     = 1'b0;
        miss_d     = 1'b0;
        bufWe      = 1'b0;
        bufWData   = '0;

        // A frame that starts while a previous one is still pending is
        // ignored until its axiiv falls.
        busyRise    = axiiv && !prevValid_q && (state_q == WAIT_CK || state_q == DRAIN);
        verdictSeen = seen_q || done;
        verdictBad  = done ? kill : bad_q;

        if (busyRise) begin
            miss_d   = 1'b1;
            ignore_d = 1'b1;
        end else if (!axiiv) begin
            ignore_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (axiiv && !ignore_q) begin
                    state_d    = COLLECT;
                    dly_d[0]   = axiid;
                    fillCnt_d  = FILL_ONE;
                    packCnt_d  = '0;
                    wptr_d     = '0;
                    overflow_d = 1'b0;
                    seen_d     = 1'b0;
                    bad_d      = 1'b0;
                end
            end

            COLLECT: begin
                if (done) begin
                    seen_d = 1'b1;
                    bad_d  = kill;
                end
                if (axiiv) begin
                    for (int i = 1; i < FCS_DIBITS; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                    dly_d[0] = axiid;
                    if (fillCnt_q == FILL_FULL) begin
                        word_d = {word_q[WIDTH-3:0], dly_q[FCS_DIBITS-1]};
                        if (packCnt_q == PACK_LAST) begin
                            packCnt_d = '0;
                            if (wptr_q == PTR_MAX) begin
                                overflow_d = 1'b1;
                            end else begin
                                bufWe    = 1'b1;
                                bufWData = word_d;
                                wptr_d   = wptr_q + PTR_ONE;
                            end
                        end else begin
                            packCnt_d = packCnt_q + PACK_ONE;
                        end
                    end else begin
                        fillCnt_d = fillCnt_q + FILL_ONE;
                    end
                end else begin
                    state_d = WAIT_CK;
                    timer_d = '0;
                end
            end

            WAIT_CK: begin
                if (done) begin
                    seen_d = 1'b1;
                    bad_d  = kill;
                end
                if (verdictSeen) begin
                    if (verdictBad || overflow_q || (wptr_q == '0)) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        rptr_d  = '0;
                        axiov_d = 1'b1;
                        axiod_d = buffer_q[0];
                        axiol_d = (wptr_q == PTR_ONE);
                    end
                end else if (timer_q == TMR_LAST) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            DRAIN: begin
                if (axiov_q && axior) begin
                    if (axiol_q) begin
                        state_d = IDLE;
                        axiov_d = 1'b0;
                        axiod_d = '0;
                        axiol_d = 1'b0;
                    end else begin
                        rptr_d  = rptrInc;
                        axiod_d = buffer_q[rptrInc[IDX_W-1:0]];
                        axiol_d = (rptrInc == lastPtr);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prevValid_q <= 1'b0;
            ignore_q    <= 1'b0;
            dly_q       <= '{default: '0};
            fillCnt_q   <= '0;
            word_q      <= '0;
            packCnt_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            seen_q      <= 1'b0;
            bad_q       <= 1'b0;
            timer_q     <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
            axiol_q     <= 1'b0;
            drop_q      <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prevValid_q <= axiiv;
            ignore_q    <= ignore_d;
            dly_q       <= dly_d;
            fillCnt_q   <= fillCnt_d;
            word_q      <= word_d;
            packCnt_q   <= packCnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            seen_q      <= seen_d;
            bad_q       <= bad_d;
            timer_q     <= timer_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
            axiol_q     <= axiol_d;
            drop_q      <= drop_d;
            miss_q      <= miss_d;
        end
    end

    // Word buffer; its contents only matter between a write and the drain,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (bufWe) begin
            buffer_q[wptr_q[IDX_W-1:0]] <= bufWData;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign axiol = axiol_q;
    assign drop  = drop_q;
    assign miss  = miss_q;

endmodule

// File: tb/tb_rx_word_gate.sv
// tb_rx_word_gate
//   Directed bench for rx_word_gate with WIDTH=44, MAX_WORDS=2. Each task
//   drives one scenario and compares the outputs against hand-computed words.
module tb_rx_word_gate;

    localparam int WIDTH     = 44;
    localparam int MAX_WORDS = 2;
    localparam int FCS       = 16;
    localparam int TIMEOUT   = 256;

    localparam logic [WIDTH-1:0] A0 = 44'hABC_DEF0_1234;
    localparam logic [WIDTH-1:0] A1 = 44'h567_89AB_CDEF;
    localparam logic [WIDTH-1:0] B0 = 44'h123_4567_89AB;
    localparam logic [WIDTH-1:0] B1 = 44'hFED_CBA9_8765;
    localparam logic [WIDTH-1:0] C0 = 44'h800_0000_0001;
    localparam logic [WIDTH-1:0] C1 = 44'h3A5_A5A5_A5A5;
    localparam logic [WIDTH-1:0] C2 = 44'h0F0_F0F0_F0F0;
    localparam logic [WIDTH-1:0] D0 = 44'hC3C_3C3C_3C3C;

    logic             clk = 1'b0;
    logic             rst;
    logic             axiiv;
    logic [1:0]       axiid;
    logic             done;
    logic             kill;
    logic             axior;
    logic             axiov;
    logic [WIDTH-1:0] axiod;
    logic             axiol;
    logic             drop;
    logic             miss;

    int checks = 0;
    int errors = 0;
    int dropCount = 0;
    int validCount = 0;
    int missCount = 0;

    rx_word_gate #(
        .WIDTH      (WIDTH),
        .MAX_WORDS  (MAX_WORDS),
        .FCS_DIBITS (FCS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .done  (done),
        .kill  (kill),
        .axior (axior),
        .axiov (axiov),
        .axiod (axiod),
        .axiol (axiol),
        .drop  (drop),
        .miss  (miss)
    );

    // 50 MHz reference clock.
    always #10 clk = ~clk;

    // Event counters, sampled before the DUT updates on each edge.
    always @(posedge clk) begin
        if (drop)  dropCount++;
        if (axiov) validCount++;
        if (miss)  missCount++;
    end

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nWords payload words MSB-first followed by FCS dibits, optionally
    // pulsing a good verdict doneBefore cycles before axiiv falls. Returns in
    // the first WAIT_CK cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                 input logic [WIDTH-1:0] w2, input int nWords,
                                 input int doneBefore);
        logic [WIDTH-1:0] wv;
        int n;
        int payload;
        payload = nWords * (WIDTH / 2);
        n = payload + FCS;
        for (int i = 0; i < n; i++) begin
            axiiv = 1'b1;
            if (i < payload) begin
                case (i / (WIDTH / 2))
                    0:       wv = w0;
                    1:       wv = w1;
                    default: wv = w2;
                endcase
                axiid = wv[WIDTH-1-2*(i%(WIDTH/2)) -: 2];
            end else begin
                axiid = 2'(i);
            end
            done = (doneBefore > 0) && (i == n - doneBefore);
            kill = 1'b0;
            tick();
        end
        axiiv = 1'b0;
        axiid = 2'b00;
        done  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; axiiv = 1'b0; axiid = 2'b00; done = 1'b0; kill = 1'b0; axior = 1'b1;
        repeat (3) tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL reset_axiov got %0b want 0", axiov); end
        checks++; if (axiod !== '0) begin errors++; $display("[TB] FAIL reset_axiod got %h want 0", axiod); end
        checks++; if (axiol !== 1'b0) begin errors++; $display("[TB] FAIL reset_axiol got %0b want 0", axiol); end
        checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop got %0b want 0", drop); end
        checks++; if (miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_miss got %0b want 0", miss); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_good_frame();
        int dBase;
        dBase = dropCount;
        axior = 1'b1;
        applyStimulus(A0, A1, '0, 2, 0);
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL good_wait got %0b want 0", axiov); end
        done = 1'b1; kill = 1'b0;
        tick();
        done = 1'b0;
        checks++; if (axiov !== 1'b1) begin errors++; $display("[TB] FAIL good_v0 got %0b want 1", axiov); end
        checks++; if (axiod !== A0) begin errors++; $display("[TB] FAIL good_w0 got %h want %h", axiod, A0); end
        checks++; if (axiol !== 1'b0) begin errors++; $display("[TB] FAIL good_l0 got %0b want 0", axiol); end
        tick();
        checks++; if (axiov !== 1'b1) begin errors++; $display("[TB] FAIL good_v1 got %0b want 1", axiov); end
        checks++; if (axiod !== A1) begin errors++; $display("[TB] FAIL good_w1 got %h want %h", axiod, A1); end
        checks++; if (axiol !== 1'b1) begin errors++; $display("[TB] FAIL good_l1 got %0b want 1", axiol); end
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL good_end got %0b want 0", axiov); end
        checks++; if (dropCount !== dBase) begin errors++; $display("[TB] FAIL good_nodrop got %0d want %0d", dropCount, dBase); end
        repeat (2) tick();
    endtask

    task automatic test_bad_frame();
        int dBase;
        int vBase;
        dBase = dropCount;
        vBase = validCount;
        applyStimulus(A0, A1, '0, 2, 0);
        tick();
        done = 1'b1; kill = 1'b1;
        tick();
        done = 1'b0; kill = 1'b0;
        checks++; if (drop !== 1'b1) begin errors++; $display("[TB] FAIL bad_drop got %0b want 1", drop); end
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL bad_axiov got %0b want 0", axiov); end
        tick();
        checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL bad_droplen got %0b want 0", drop); end
        repeat (3) tick();
        checks++; if (validCount !== vBase) begin errors++; $display("[TB] FAIL bad_novalid got %0d want %0d", validCount, vBase); end
        checks++; if (dropCount !== dBase + 1) begin errors++; $display("[TB] FAIL bad_dropcnt got %0d want %0d", dropCount, dBase + 1); end
    endtask

    task automatic test_early_verdict();
        applyStimulus(B0, B1, '0, 2, 10);
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL early_wait got %0b want 0", axiov); end
        tick();
        checks++; if (axiov !== 1'b1) begin errors++; $display("[TB] FAIL early_v0 got %0b want 1", axiov); end
        checks++; if (axiod !== B0) begin errors++; $display("[TB] FAIL early_w0 got %h want %h", axiod, B0); end
        checks++; if (axiol !== 1'b0) begin errors++; $display("[TB] FAIL early_l0 got %0b want 0", axiol); end
        tick();
        checks++; if (axiod !== B1) begin errors++; $display("[TB] FAIL early_w1 got %h want %h", axiod, B1); end
        checks++; if (axiol !== 1'b1) begin errors++; $display("[TB] FAIL early_l1 got %0b want 1", axiol); end
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL early_end got %0b want 0", axiov); end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        int dBase;
        int vBase;
        dBase = dropCount;
        vBase = validCount;
        applyStimulus(C0, C1, C2, 3, 0);
        tick();
        done = 1'b1; kill = 1'b0;
        tick();
        done = 1'b0;
        checks++; if (drop !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drop got %0b want 1", drop); end
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL ovf_axiov got %0b want 0", axiov); end
        repeat (2) tick();
        applyStimulus(D0, '0, '0, 1, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (axiov !== 1'b1) begin errors++; $display("[TB] FAIL one_v got %0b want 1", axiov); end
        checks++; if (axiod !== D0) begin errors++; $display("[TB] FAIL one_w got %h want %h", axiod, D0); end
        checks++; if (axiol !== 1'b1) begin errors++; $display("[TB] FAIL one_l got %0b want 1", axiol); end
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL one_end got %0b want 0", axiov); end
        checks++; if (dropCount !== dBase + 1) begin errors++; $display("[TB] FAIL ovf_dropcnt got %0d want %0d", dropCount, dBase + 1); end
        checks++; if (validCount !== vBase + 1) begin errors++; $display("[TB] FAIL ovf_validcnt got %0d want %0d", validCount, vBase + 1); end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        axior = 1'b0;
        applyStimulus(A1, A0, '0, 2, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (axiod !== A1) begin errors++; $display("[TB] FAIL bp_w0 got %h want %h", axiod, A1); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (axiov !== 1'b1 || axiod !== A1 || axiol !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold%0d got v=%0b d=%h l=%0b want v=1 d=%h l=0", k, axiov, axiod, axiol, A1);
            end
        end
        axior = 1'b1;
        tick();
        checks++; if (axiod !== A0) begin errors++; $display("[TB] FAIL bp_w1 got %h want %h", axiod, A0); end
        checks++; if (axiol !== 1'b1) begin errors++; $display("[TB] FAIL bp_l1 got %0b want 1", axiol); end
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL bp_end got %0b want 0", axiov); end
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int vBase;
        vBase = validCount;
        applyStimulus(A0, A1, '0, 2, 0);
        repeat (TIMEOUT - 1) tick();
        checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %0b want 0", drop); end
        tick();
        checks++; if (drop !== 1'b1) begin errors++; $display("[TB] FAIL to_drop got %0b want 1", drop); end
        tick();
        checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL to_droplen got %0b want 0", drop); end
        checks++; if (validCount !== vBase) begin errors++; $display("[TB] FAIL to_novalid got %0d want %0d", validCount, vBase); end
        repeat (2) tick();
    endtask

    task automatic test_miss();
        int mBase;
        int dBase;
        int vBase;
        mBase = missCount;
        axior = 1'b0;
        applyStimulus(B0, B1, '0, 2, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (axiod !== B0) begin errors++; $display("[TB] FAIL miss_w0 got %h want %h", axiod, B0); end
        axiiv = 1'b1; axiid = 2'b10;
        tick();
        checks++; if (miss !== 1'b1) begin errors++; $display("[TB] FAIL miss_pulse got %0b want 1", miss); end
        tick();
        checks++; if (miss !== 1'b0) begin errors++; $display("[TB] FAIL miss_len got %0b want 0", miss); end
        axior = 1'b1;
        tick();
        checks++; if (axiod !== B1 || axiol !== 1'b1) begin
            errors++; $display("[TB] FAIL miss_w1 got d=%h l=%0b want d=%h l=1", axiod, axiol, B1);
        end
        tick();
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL miss_end got %0b want 0", axiov); end
        repeat (4) tick();
        axiiv = 1'b0; axiid = 2'b00;
        repeat (2) tick();
        dBase = dropCount;
        vBase = validCount;
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (4) tick();
        checks++; if (dropCount !== dBase) begin errors++; $display("[TB] FAIL miss_ignored_drop got %0d want %0d", dropCount, dBase); end
        checks++; if (validCount !== vBase) begin errors++; $display("[TB] FAIL miss_ignored_valid got %0d want %0d", validCount, vBase); end
        checks++; if (missCount !== mBase + 1) begin errors++; $display("[TB] FAIL miss_count got %0d want %0d", missCount, mBase + 1); end
    endtask

    task automatic test_reset_drain();
        int vBase;
        axior = 1'b1;
        applyStimulus(B1, B0, '0, 2, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (axiod !== B1) begin errors++; $display("[TB] FAIL rstd_w0 got %h want %h", axiod, B1); end
        tick();
        checks++; if (axiod !== B0) begin errors++; $display("[TB] FAIL rstd_w1 got %h want %h", axiod, B0); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (axiov !== 1'b0) begin errors++; $display("[TB] FAIL rstd_axiov got %0b want 0", axiov); end
        checks++; if (axiod !== '0) begin errors++; $display("[TB] FAIL rstd_axiod got %h want 0", axiod); end
        checks++; if (axiol !== 1'b0) begin errors++; $display("[TB] FAIL rstd_axiol got %0b want 0", axiol); end
        repeat (2) tick();
        rst = 1'b0;
        vBase = validCount;
        repeat (5) tick();
        checks++; if (validCount !== vBase) begin errors++; $display("[TB] FAIL rstd_nomore got %0d want %0d", validCount, vBase); end
    endtask

    initial begin
        $display("[TB] rx_word_gate directed test start");
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_early_verdict();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_miss();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
